// File: rtl/demux4_router_pkg.sv
// Shared types and constants for the 1-to-4 registered result distributor.
package demux4_router_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned NCH       = 4;
    localparam int unsigned SEL_W     = 2;

    typedef enum logic [SEL_W-1:0] {
        DST_RF   = 2'b00,
        DST_HILO = 2'b01,
        DST_CP0  = 2'b10,
        DST_DBG  = 2'b11
    } dst_e;

    // Per-cycle producer control payload
    typedef struct packed {
        logic flush;
        logic valid;
        dst_e dst;
    } route_ctl_t;

    // One-hot channel select for a destination code
    function automatic logic [NCH-1:0] dst_decode(input dst_e dst);
        logic [NCH-1:0] sel;
        sel = '0;
        case (dst)
            DST_RF:   sel = 4'b0001;
            DST_HILO: sel = 4'b0010;
            DST_CP0:  sel = 4'b0100;
            DST_DBG:  sel = 4'b1000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/demux4_router_if.sv
// Producer/consumer bundle of the distributor; master = environment, slave = router.
interface demux4_router_if
    import demux4_router_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic             iFlush;
    logic [WIDTH-1:0] iData;
    logic [SEL_W-1:0] iS;
    logic             iValid;
    logic             oReady;
    logic [WIDTH-1:0] oZ0;
    logic [WIDTH-1:0] oZ1;
    logic [WIDTH-1:0] oZ2;
    logic [WIDTH-1:0] oZ3;
    logic [NCH-1:0]   oValid;
    logic [NCH-1:0]   iReady;
    logic [CNT_W-1:0] oCnt0;
    logic [CNT_W-1:0] oCnt1;
    logic [CNT_W-1:0] oCnt2;
    logic [CNT_W-1:0] oCnt3;

    modport master (
        output iFlush, iData, iS, iValid, iReady,
        input  oReady, oZ0, oZ1, oZ2, oZ3, oValid, oCnt0, oCnt1, oCnt2, oCnt3
    );

    modport slave (
        input  iFlush, iData, iS, iValid, iReady,
        output oReady, oZ0, oZ1, oZ2, oZ3, oValid, oCnt0, oCnt1, oCnt2, oCnt3
    );

endinterface

// File: rtl/demux4_router_slot.sv
// One output channel: a single registered entry with valid/ready handshake and
// a wrapping count of words handed to the consumer.
module demux4_router_slot
    import demux4_router_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iFlush,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iData,
    input  logic             iReady,
    output logic [WIDTH-1:0] oData,
    output logic             oValid,
    output logic [CNT_W-1:0] oCnt
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;
    logic             w_drain;

    assign w_drain = r_valid & iReady;

    // Flush beats refill beats drain; data only moves on a load
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (iFlush) begin
            r_valid <= 1'b0;
        end else if (iLoad) begin
            r_data  <= iData;
            r_valid <= 1'b1;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    // The consumer saw valid & ready, so the word counts even under flush
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_cnt <= '0;
        end else if (w_drain) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign oData  = r_data;
    assign oValid = r_valid;
    assign oCnt   = r_cnt;

endmodule

// File: rtl/demux4_router.sv
// Registered 1-to-4 distributor: routes each tagged word to one of four
// independent single-entry channels so one stalled consumer blocks only itself.
module demux4_router
    import demux4_router_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic           iClk,
    input  logic           iRst_n,
    demux4_router_if.slave bus
);

    route_ctl_t       w_ctl;
    logic [NCH-1:0]   w_sel;
    logic [NCH-1:0]   w_load;
    logic [NCH-1:0]   w_valid;
    logic             w_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_z   [NCH];
    logic [CNT_W-1:0] w_cnt [NCH];

    assign w_ctl = '{flush: bus.iFlush, valid: bus.iValid, dst: dst_e'(bus.iS)};
    assign w_sel = dst_decode(w_ctl.dst);

    // Ready looks only at the addressed channel: empty, or draining this cycle
    assign w_ready  = ~w_ctl.flush & (|(w_sel & (~w_valid | bus.iReady)));
    assign w_accept = w_ctl.valid & w_ready;
    assign w_load   = {NCH{w_accept}} & w_sel;

    for (genvar g = 0; g < NCH; g++) begin : g_slot
        demux4_router_slot #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_slot (
            .iClk   (iClk),
            .iRst_n (iRst_n),
            .iFlush (w_ctl.flush),
            .iLoad  (w_load[g]),
            .iData  (bus.iData),
            .iReady (bus.iReady[g]),
            .oData  (w_z[g]),
            .oValid (w_valid[g]),
            .oCnt   (w_cnt[g])
        );
    end

    assign bus.oReady = w_ready;
    assign bus.oValid = w_valid;
    assign bus.oZ0    = w_z[0];
    assign bus.oZ1    = w_z[1];
    assign bus.oZ2    = w_z[2];
    assign bus.oZ3    = w_z[3];
    assign bus.oCnt0  = w_cnt[0];
    assign bus.oCnt1  = w_cnt[1];
    assign bus.oCnt2  = w_cnt[2];
    assign bus.oCnt3  = w_cnt[3];

endmodule

// File: doc/demux4_router.md
Name: demux4_router

Overview:
- Registered 1-to-4 distributor: the opposite of the 4-way result selector.
- Accepts one 32-bit word per cycle tagged with a 2-bit destination and delivers it to one of four output channels.
- Each output channel holds one registered entry with a valid/ready handshake.
- Sits between the execute/memory result path and four independent consumers (e.g. register-file write port, HI/LO, CP0, debug/LED port); lets one stalled consumer hold without blocking traffic to the others.

Parameters:
- WIDTH, 32, data width of input and every output channel.
- CNT_W, 16, width of each per-channel delivered-word counter.

Ports:
- iClk  input  1  clock, all state updates on rising edge.
- iRst_n  input  1  asynchronous active-low reset.
- iFlush  input  1  synchronous clear of all channel entries; counters kept.
- iData  input  WIDTH  word to route.
- iS  input  2  destination channel: 00→0, 01→1, 10→2, 11→3.
- iValid  input  1  iData/iS valid this cycle.
- oReady  output  1  router accepts the word this cycle.
- oZ0, oZ1, oZ2, oZ3  output  WIDTH  channel data registers.
- oValid  output  4  per-channel entry valid, bit n = channel n.
- iReady  input  4  per-channel consumer ready, bit n = channel n.
- oCnt0, oCnt1, oCnt2, oCnt3  output  CNT_W  words delivered per channel.

Behaviour:
- Reset (iRst_n low, asynchronous): oValid=4'b0000, oZ0..oZ3=0, oCnt0..oCnt3=0. All take effect immediately without a clock edge and hold while iRst_n is low.
- Accept: accept = iValid & oReady.
  - oReady is combinational: oReady = ~oValid[iS] | iReady[iS].
  - oReady depends only on the selected channel; the other channels' state does not affect it.
- Drain: channel n drains on a cycle with oValid[n] & iReady[n]. At that edge oCntn increments by 1, wrapping from 2^CNT_W-1 to 0 with no saturation.
- Channel n next state, evaluated in priority order per edge:
  1. iFlush: oValid[n]←0. oZn and the counters are unchanged. A drain in the same cycle still counts, because the consumer saw valid & ready.
  2. Accept with iS==n: oZn←iData, oValid[n]←1. Covers simultaneous drain and refill: the old word counts and the new word loads, giving full throughput.
  3. Drain without refill: oValid[n]←0. oZn holds its last value.
  4. Otherwise: hold.
- While iFlush is high, oReady is forced to 0; no word is accepted during a flush cycle.
- Latency: a word accepted at edge k appears on oZn with oValid[n]=1 after edge k. Minimum one cycle from input to output.
- Throughput: one word per cycle when consumers keep iReady high.
- Ordering: preserved per channel. No ordering guarantee across channels.
- Input held by the producer: iData/iS must stay stable while iValid=1 & oReady=0. The router does not latch unaccepted input.
- A stall on channel n (oValid[n]=1, iReady[n]=0) blocks only inputs addressed to n.
- An iS change while iValid is low has no effect.
- iValid=0: no channel loads regardless of iS.
- Outputs oZn change only on accept. No X propagation: every state bit is reset.

Decomposition:
- Shared package:
  - WIDTH default, channel count NCH=4.
  - Destination encodings: DST_RF=2'b00, DST_HILO=2'b01, DST_CP0=2'b10, DST_DBG=2'b11.
- One natural sub-module, demux_slot: a one-entry register holding data, valid and counter, with inputs load/flush/ready. Instantiate it four times. The top level contains only the select decode and the oReady mux.

Test Plan:
- Reset: assert iRst_n=0 mid-run with oValid=4'b1010 → oValid=0, oZ*=0, oCnt*=0 immediately, before the next clock edge.
- Routing: iReady=4'hF, send 32'h11111111/iS=00, 32'h22222222/01, 32'h33333333/10, 32'h44444444/11 on consecutive cycles → each oZn shows its word one cycle after acceptance; oCnt0..3 each end at 1; oReady stays 1.
- Back-pressure: iReady[2]=0, send 32'hA/iS=10 then 32'hB/iS=10 → first word held on oZ2, oReady=0 for the second. Release iReady[2] → same cycle oReady=1, the next edge loads 32'hB, oCnt2=1.
- Independence: channel 1 stalled full, send 32'hC/iS=00 → accepted; oZ0=32'hC next cycle; oZ1 unchanged.
- Flush: oValid=4'b1111, iFlush=1 with iValid=1 → oValid=0 next cycle, oReady=0 during flush, oZ* values and oCnt* unchanged.
- Counter wrap: CNT_W=4, stream 17 words to channel 3 with iReady[3]=1 → oCnt3=1.
